// File: rtl/data_memory_pkg.sv
// Shared encodings for the MA-stage data memory: access sizes (also used by
// the control unit), FSM state codes and the latched request record.
package data_memory_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_DONE = 2'd2;

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == MEM_HALF) && lo[0]) || ((size == MEM_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / data replication and
// load lane extraction with sign or zero extension.
module dmem_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] LN = g[1:0];
    assign o_be[g] = (i_size == MEM_WORD)
                   | ((i_size == MEM_HALF) & (LN[1] == i_lane[1]))
                   | ((i_size == MEM_BYTE) & (LN == i_lane));
  end

  // Replicating narrow data across lanes lets the byte enables alone pick the target.
  always_comb begin
    o_wdata = i_wdata;
    case (i_size)
      MEM_BYTE: o_wdata = {4{i_wdata[7:0]}};
      MEM_HALF: o_wdata = {2{i_wdata[15:0]}};
      default:  o_wdata = i_wdata;
    endcase
  end

  assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_rdata = i_rword;
    case (i_size)
      MEM_BYTE: o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      MEM_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:  o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle MA-stage data memory: IDLE/WAIT/DONE FSM, latency counter,
// request latches and the word array; busy stalls IF..MA while in flight.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW+1:0]   r_addr;
  dmem_req_t       r_req;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [1:0]      w_next;
  logic            w_wr_req, w_rd_req, w_req, w_mis, w_idle, w_accept, w_to_done;
  logic [1:0]      w_size;
  logic [AW+1:0]   w_acc_addr;
  logic [1:0]      w_acc_size;
  logic            w_acc_wr, w_acc_uns;
  logic [31:0]     w_acc_wdata;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep, w_load;
  logic            w_unused_addr;

  // A simultaneous read is dropped: the store size governs the access.
  assign w_wr_req = |mem_write;
  assign w_rd_req = |mem_read;
  assign w_req    = w_wr_req | w_rd_req;
  assign w_size   = w_wr_req ? mem_write : mem_read;
  assign w_mis    = is_misaligned(w_size, address[1:0]);
  assign w_idle   = (r_state == DMEM_IDLE);
  assign w_accept = w_idle & w_req & ~w_mis;

  assign misaligned = w_idle & w_req & w_mis;
  assign busy       = w_accept | (r_state == DMEM_WAIT);
  assign read_data  = r_rdata;

  assign w_unused_addr = ^address[31:AW+2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      DMEM_IDLE: if (w_accept) w_next = (ACCESS_LATENCY > 1) ? DMEM_WAIT : DMEM_DONE;
      DMEM_WAIT: if (r_cnt == CW'(1)) w_next = DMEM_DONE;
      DMEM_DONE: w_next = DMEM_IDLE;
      default:   w_next = DMEM_IDLE;
    endcase
  end

  assign w_to_done = (w_next == DMEM_DONE);

  // With single-cycle latency the access fires straight from IDLE, before the latches load.
  assign w_acc_addr  = w_idle ? address[AW+1:0] : r_addr;
  assign w_acc_size  = w_idle ? w_size          : r_req.size;
  assign w_acc_wr    = w_idle ? w_wr_req        : r_req.is_wr;
  assign w_acc_uns   = w_idle ? load_unsigned   : r_req.uns;
  assign w_acc_wdata = w_idle ? write_data      : r_req.wdata;
  assign w_idx       = w_acc_addr[AW+1:2];

  dmem_lane_align u_align (
    .i_size     (w_acc_size),
    .i_lane     (w_acc_addr[1:0]),
    .i_unsigned (w_acc_uns),
    .i_wdata    (w_acc_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_rdata    (w_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DMEM_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr      <= address[AW+1:0];
        r_req.is_wr <= w_wr_req;
        r_req.size  <= w_size;
        r_req.uns   <= load_unsigned;
        r_req.wdata <= write_data;
        r_cnt       <= CW'(ACCESS_LATENCY - 1);
      end else if (r_state == DMEM_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_to_done && !w_acc_wr) r_rdata <= w_load;
    end
  end

  // Array is never reset; reset low suppresses any pending store.
  always_ff @(posedge clk) begin
    if (reset && w_to_done && w_acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a read_data scoreboard popped by a
// monitor on each completed access (busy falling outside reset).
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_read, mem_write;
  logic        load_unsigned;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busy, misaligned;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic        prev_busy = 1'b0;

  data_memory #(.DEPTH_WORDS(1024), .ACCESS_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(read_data), .busy(busy), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the DONE cycle is the first cycle with busy low after busy high.
  always @(negedge clk) begin
    if (!reset) prev_busy = 1'b0;
    else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) chk("sb_unexpected_done", 32'h1, 32'h0);
        else chk("sb_read_data", read_data, exp_q.pop_front());
      end
      prev_busy = busy;
    end
  end

  task automatic idle_inputs();
    mem_read = MEM_NONE; mem_write = MEM_NONE; load_unsigned = 1'b0;
    address = '0; write_data = '0;
  endtask

  // One aligned access; inputs dropped after the request cycle.
  task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; load_unsigned = uns; address = a; write_data = d;
    exp_q.push_back(exp);
    @(negedge clk); chk("busy_req_cycle", {31'b0, busy}, 32'h1);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); chk("busy_wait_cycle", {31'b0, busy}, 32'h1);
    @(negedge clk); chk("busy_done_cycle", {31'b0, busy}, 32'h0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    access(MEM_NONE, sz, 1'b0, a, d, last_rd);
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
    access(sz, MEM_NONE, uns, a, 32'h0, exp);
    last_rd = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_misaligned", {31'b0, misaligned}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Word store / load
    store(MEM_WORD, 32'h10, 32'hDEADBEEF);
    load(MEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

    // Byte / half loads with extension
    store(MEM_WORD, 32'h20, 32'h800080F0);
    load(MEM_BYTE, 1'b0, 32'h20, 32'hFFFFFFF0);
    load(MEM_BYTE, 1'b1, 32'h20, 32'h000000F0);
    load(MEM_HALF, 1'b0, 32'h22, 32'hFFFF8000);
    load(MEM_HALF, 1'b1, 32'h22, 32'h00008000);

    // Partial stores
    store(MEM_WORD, 32'h30, 32'h11223344);
    store(MEM_BYTE, 32'h31, 32'h000000AA);
    load(MEM_WORD, 1'b0, 32'h30, 32'h1122AA44);
    store(MEM_HALF, 32'h32, 32'h0000BEEF);
    load(MEM_WORD, 1'b0, 32'h30, 32'hBEEFAA44);
    load(MEM_WORD, 1'b0, 32'h1030, 32'hBEEFAA44);  // address wrap

    // Misaligned word read held for two cycles
    store(MEM_WORD, 32'h40, 32'hCAFEF00D);
    load(MEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    mem_read = MEM_WORD; address = 32'h41;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_busy", {31'b0, busy}, 32'h0);
      chk("mis_read_data", read_data, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    mem_read = MEM_HALF; address = 32'h43;
    @(negedge clk); chk("mis_half_flag", {31'b0, misaligned}, 32'h1);
    idle_inputs();
    load(MEM_WORD, 1'b0, 32'h40, 32'hCAFEF00D);

    // Reset during WAIT discards the store
    store(MEM_WORD, 32'h50, 32'hAAAA5555);
    load(MEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    mem_write = MEM_WORD; address = 32'h50; write_data = 32'h12345678;
    @(negedge clk); chk("rst_req_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1; idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("rst_async_busy", {31'b0, busy}, 32'h0);
    chk("rst_async_read_data", read_data, 32'h0);
    @(posedge clk); @(negedge clk); #2 reset = 1'b1;
    last_rd = 32'h0;
    load(MEM_WORD, 1'b0, 32'h50, 32'hAAAA5555);

    // Simultaneous read+write held through DONE
    @(posedge clk); #1;
    mem_read = MEM_WORD; mem_write = MEM_WORD; address = 32'h60; write_data = 32'h5A5A5A5A;
    exp_q.push_back(last_rd);
    @(negedge clk); chk("rw_busy_t0", {31'b0, busy}, 32'h1);
    @(negedge clk); chk("rw_busy_t1", {31'b0, busy}, 32'h1);
    @(negedge clk); chk("rw_busy_done", {31'b0, busy}, 32'h0);
    chk("rw_mis_done", {31'b0, misaligned}, 32'h0);
    exp_q.push_back(last_rd);
    @(negedge clk); chk("rw_reaccept_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); chk("rw2_busy_wait", {31'b0, busy}, 32'h1);
    @(negedge clk); chk("rw2_busy_done", {31'b0, busy}, 32'h0);
    load(MEM_WORD, 1'b0, 32'h60, 32'h5A5A5A5A);

    repeat (3) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Multi-cycle data memory for the MA stage of the RV32IM pipeline.
- Consumes the MA-stage address, store data and 2-bit read/write size controls. Returns load data to the MA_WB pipeline register.
- Asserts `busy` so the hazard logic can stall IF..MA while an access is in flight.
- Handles byte, half and word loads and stores with lane alignment, sign/zero extension and misalignment detection.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- ACCESS_LATENCY, 2, number of cycles `busy` is high per access; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  2  load size: 00 none, 01 byte, 10 half, 11 word.
- mem_write  input  2  store size, same encoding as mem_read.
- load_unsigned  input  1  1 = zero-extend byte/half loads; 0 = sign-extend.
- address  input  32  byte address (MA-stage ALU result).
- write_data  input  32  store data; low bits are used for byte/half stores.
- read_data  output  32  load result, extended to 32 bits.
- busy  output  1  stall request to the pipeline.
- misaligned  output  1  misaligned-access flag; combinational, IDLE only.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; read_data=0; busy=0; misaligned=0.
  - Latency counter is cleared.
  - Memory array contents are not reset.
- Request = (mem_read!=00 || mem_write!=00), sampled only in IDLE.
- If mem_write!=00 and mem_read!=00 in the same cycle, the write takes priority and the read is ignored.
- Word index = address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Misalignment rule: half access with address[0]=1, or word access with address[1:0]!=00.
  - misaligned=1 combinationally in IDLE; busy stays 0.
  - No array access occurs, state stays IDLE, read_data is unchanged.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - busy = valid aligned request (combinational, same cycle the request appears).
  - Aligned request latches address, size, write_data and load_unsigned.
  - Counter loads ACCESS_LATENCY-1.
  - Next state is WAIT if ACCESS_LATENCY>1, else DONE.
- WAIT:
  - busy=1.
  - Counter decrements each cycle.
  - When the counter reaches 0, next state is DONE.
- Transition into DONE (the same edge that enters DONE):
  - Store: only the addressed lanes are written.
    - Byte store: lane address[1:0] is written with write_data[7:0].
    - Half store: lanes {address[1],0} and {address[1],1} are written with write_data[15:0].
    - Word store: all four lanes are written.
  - Load: read_data is registered.
    - Byte load: lane selected by address[1:0].
    - Half load: selected by address[1].
    - Result is extended per the latched load_unsigned.
- DONE:
  - busy=0; inputs are ignored for exactly one cycle.
  - The still-held stalled request is not re-accepted.
  - Next state is IDLE.
- Latency: an aligned request seen in cycle T holds busy high for cycles T..T+ACCESS_LATENCY-1.
  - read_data is valid from cycle T+ACCESS_LATENCY (DONE).
  - read_data holds its value until the next completed load.
- A store leaves read_data unchanged.
- Back-to-back requests: a new request can be accepted in the cycle after DONE, giving a minimum spacing of ACCESS_LATENCY+1 cycles.
- Reset mid-access: a pending store is discarded and the array is unchanged; state goes to IDLE.
- Request inputs changing during WAIT have no effect, because the latched copies are used.

Decomposition:
- Shared package holds:
  - size encodings MEM_NONE=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10, MEM_WORD=2'b11;
  - FSM state encodings DMEM_IDLE, DMEM_WAIT, DMEM_DONE.
- The size encodings are shared with the control unit.
- Sub-module `dmem_lane_align` (combinational) contains:
  - store byte-enable generation and data replication;
  - load lane extraction and sign/zero extension.
- Top level keeps the FSM, counter, latches and array.

Test Plan:
- Word store then word load, all with ACCESS_LATENCY=2:
  - Stimulus: mem_write=11, addr 0x10, data 0xDEADBEEF; then mem_read=11, addr 0x10.
  - busy high for 2 cycles per access, low in DONE.
  - read_data=0xDEADBEEF in the load's DONE cycle.
- Byte and half loads:
  - Setup: memory word at 0x20 = 0x8000_80F0.
  - Byte load at 0x20 with load_unsigned=0 gives 0xFFFFFFF0; with load_unsigned=1 gives 0x000000F0.
  - Half load at 0x22 with load_unsigned=0 gives 0xFFFF8000.
- Partial store:
  - Setup: word 0x30 = 0x11223344.
  - Byte store 0xAA at 0x31, then word load of 0x30, gives 0x1122AA44.
  - Half store 0xBEEF at 0x32, then word load of 0x30, gives 0xBEEFAA44.
- Misaligned access:
  - Word read at 0x41 gives misaligned=1 and busy=0 in the same cycle.
  - State stays IDLE and read_data is unchanged.
  - A following load of 0x40 returns the original word.
- Reset during WAIT:
  - Word store 0x12345678 to 0x50; assert reset low in its WAIT cycle.
  - busy=0 and read_data=0 immediately (asynchronous).
  - A subsequent load of 0x50 returns the prior contents.
- Simultaneous read and write, with a held request:
  - mem_read=11 and mem_write=11 at 0x60 with data 0x5A5A5A5A: the write is performed and read_data is unchanged.
  - Holding the inputs through DONE does not re-trigger the request.
  - The request is re-accepted only in the following IDLE cycle.
